// File: rtl/fibonacci_sequencer.sv
// Iterative Fibonacci engine: computes f(idx_i) one step per cycle.
// Results above MAX_VAL are clamped to MAX_VAL and flagged with overflow_o.
module fibonacci_sequencer #(
  parameter int W       = 20,
  parameter int MAX_VAL = 999_999
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [31:0]  idx_i,
  output logic         ready_o,
  output logic         done_o,
  output logic [W-1:0] fib_o,
  output logic         overflow_o
);

  typedef enum logic [1:0] {IDLE, OP, DONE} state_e;

  localparam logic [W:0]   MAX_T = (W+1)'(MAX_VAL);
  localparam logic [W-1:0] MAX_R = W'(MAX_VAL);

  state_e         state_q, state_d;
  logic [31:0]    n_q, n_d;
  logic [W:0]     t0_q, t0_d, t1_q, t1_d;
  logic [W-1:0]   fib_q, fib_d;
  logic           ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    fib_d   = fib_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          n_d     = idx_i;
          t0_d    = '0;
          t1_d    = (W+1)'(1);
          state_d = OP;
        end
      end
      OP: begin
        if (n_q == '0) begin
          fib_d   = t0_q[W-1:0];
          ovf_d   = 1'b0;
          state_d = DONE;
        end else if (t1_q > MAX_T) begin
          // f(n) >= f(k+1) here, so the result is already known to clamp
          fib_d   = MAX_R;
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          t0_d = t1_q;
          t1_d = t0_q + t1_q;
          n_d  = n_q - 32'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      n_q     <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      fib_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      fib_q   <= fib_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign done_o     = (state_q == DONE);
  assign fib_o      = fib_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_fibonacci_sequencer.sv
// Directed bench for fibonacci_sequencer: latency, result, overflow, abort and hold cases.
module tb_fibonacci_sequencer;

  localparam int W = 20;

  logic         clk_i = 1'b0;
  logic         reset_i, start_i;
  logic [31:0]  idx_i;
  logic         ready_o, done_o, overflow_o;
  logic [W-1:0] fib_o;

  int checks = 0;
  int failures = 0;
  int overlap = 0;

  fibonacci_sequencer #(.W(W), .MAX_VAL(999_999)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .idx_i(idx_i),
    .ready_o(ready_o), .done_o(done_o), .fib_o(fib_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (ready_o && done_o) overlap++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Leaves the bench 1 time unit into cycle 1 of the run.
  task automatic kick(input logic [31:0] idx);
    start_i = 1'b1;
    idx_i   = idx;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    idx_i   = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (!done_o && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] idx, input int exp_cyc,
                     input logic [31:0] exp_fib, input logic exp_ovf);
    int cyc;
    chk({tag, "_ready0"}, 32'(ready_o), 1);
    kick(idx);
    wait_done(1, cyc);
    chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_fib"}, 32'(fib_o), exp_fib);
    chk({tag, "_ovf"}, 32'(overflow_o), 32'(exp_ovf));
    @(posedge clk_i); #1;
    chk({tag, "_ready_after"}, 32'(ready_o), 1);
    chk({tag, "_done_pulse"}, 32'(done_o), 0);
  endtask

  initial begin
    int cyc;
    int stray;
    reset_i = 1'b1; start_i = 1'b0; idx_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_fib", 32'(fib_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);

    run("idx0", 32'd0, 2, 0, 1'b0);
    run("idx10", 32'd10, 12, 55, 1'b0);
    run("idx1", 32'd1, 3, 1, 1'b0);
    run("idx2", 32'd2, 4, 1, 1'b0);
    run("idx30", 32'd30, 32, 832040, 1'b0);
    run("idx31", 32'd31, 32, 999999, 1'b1);
    run("idxmax", 32'hFFFF_FFFF, 32, 999999, 1'b1);

    // Second start in cycle 5 must be ignored.
    kick(32'd20);
    repeat (4) begin @(posedge clk_i); #1; end
    start_i = 1'b1; idx_i = 32'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done(6, cyc);
    chk("repulse_cycle", 32'(cyc), 22);
    chk("repulse_fib", 32'(fib_o), 6765);
    @(posedge clk_i); #1;
    chk("repulse_ready", 32'(ready_o), 1);
    repeat (3) begin @(posedge clk_i); #1; end
    chk("repulse_hold", 32'(fib_o), 6765);

    // Reset in cycle 10 aborts the run.
    kick(32'd25);
    repeat (9) begin @(posedge clk_i); #1; end
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    chk("abort_ready", 32'(ready_o), 1);
    chk("abort_fib", 32'(fib_o), 0);
    chk("abort_ovf", 32'(overflow_o), 0);
    stray = 0;
    repeat (30) begin
      if (done_o) stray++;
      @(posedge clk_i); #1;
    end
    chk("abort_no_done", 32'(stray), 0);
    run("after_abort", 32'd5, 7, 5, 1'b0);

    // start held through DONE relaunches on the first IDLE cycle.
    start_i = 1'b1; idx_i = 32'd0;
    @(posedge clk_i); #1;
    wait_done(1, cyc);
    chk("held_first", 32'(cyc), 2);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    wait_done(4, cyc);
    chk("held_second", 32'(cyc), 5);
    start_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end

    chk("ready_done_excl", 32'(overlap), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
